// File: rtl/iter_divider_pkg.sv
// Package div_pkg: shared definitions for the iterative divider.
//   state_t : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   clog2() : constant-evaluable ceil(log2(value)), used to size the step counter
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Interface iter_divider_if: request/result bundle of the iterative divider.
//   master : requester (start, is_signed, dividend, divisor out; status/results in)
//   slave  : divider   (request in; busy, done, quotient, remainder, div_by_zero out)
interface iter_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/iter_divider_step.sv
// Module div_step: one combinational restoring-division step.
//   rem      [WIDTH:0]   partial remainder before the step
//   qbit_in              next dividend bit shifted into the remainder
//   dvsr     [WIDTH-1:0] divisor magnitude
//   rem_next [WIDTH:0]   partial remainder after the step
//   qbit                 quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             qbit_in,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH:0]   rem_next,
   output logic             qbit
);
   // One guard bit above the shifted remainder: the top bit is the borrow.
   logic [WIDTH+1:0] diff;

   always_comb begin
      diff     = {rem, qbit_in} - {2'b00, dvsr};
      qbit     = ~diff[WIDTH+1];
      rem_next = qbit ? diff[WIDTH:0] : {rem[WIDTH-1:0], qbit_in};
   end
endmodule

// File: rtl/iter_divider.sv
// Module iter_divider: multi-cycle restoring divider (DIV/DIVU, HI/LO results).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : iter_divider_if.slave (start/is_signed/dividend/divisor in;
//                busy/done/quotient/remainder/div_by_zero out)
// One quotient bit per RUN cycle on operand magnitudes, sign fix-up on the
// final step. Divide by zero finishes immediately with q=all ones, r=dividend.
// Build option: DIV_EARLY_OUT_EN finishes immediately when |dividend| < |divisor|.
module iter_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   iter_divider_if.slave bus
);
   localparam int unsigned CW = clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] q_fin, r_fin, abs_dvd, abs_dvs;
   logic             accept;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .qbit_in  (q_q[WIDTH-1]),
      .dvsr     (dvsr_q),
      .rem_next (step_rem),
      .qbit     (step_qbit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      q_d         = q_q;
      dvsr_d      = dvsr_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      q_fin   = {q_q[WIDTH-2:0], step_qbit};
      r_fin   = step_rem[WIDTH-1:0];
      abs_dvd = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
      abs_dvs = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
      accept  = bus.start && (state_q != S_RUN);

      if (state_q == S_RUN) begin
         rem_d = step_rem;
         q_d   = q_fin;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d     = S_DONE;
            quotient_d  = neg_quo_q ? -q_fin : q_fin;
            remainder_d = neg_rem_q ? -r_fin : r_fin;
         end
      end else if (accept) begin
         // The dividend magnitude sits in the quotient shift register and
         // feeds the remainder MSB-first as quotient bits fill from the LSB.
         neg_quo_d = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
         neg_rem_d = bus.is_signed && bus.dividend[WIDTH-1];
         dvsr_d    = abs_dvs;
         q_d       = abs_dvd;
         rem_d     = '0;
         cnt_d     = CW'(WIDTH);
         dbz_d     = 1'b0;
         if (bus.divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
         end
`ifdef DIV_EARLY_OUT_EN
         else if (abs_dvd < abs_dvs) begin
            state_d     = S_DONE;
            quotient_d  = '0;
            remainder_d = bus.dividend;
         end
`endif
         else begin
            state_d = S_RUN;
         end
      end else begin
         state_d = S_IDLE;
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         dvsr_q      <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         q_q         <= q_d;
         dvsr_q      <= dvsr_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_divider.sv
// Testbench for iter_divider: scoreboard of expected results pushed at issue,
// popped and compared when done is observed.
module tb_iter_divider;
   localparam int unsigned W = 32;
   localparam int EXP_LAT = W + 1;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EO_ON = 1'b1;
`else
   localparam bit EO_ON = 1'b0;
`endif
   localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   iter_divider_if #(.WIDTH(W)) bus ();
   iter_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz, input int lat);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [W-1:0] ma, mb;
      ma = (sgn && a[W-1]) ? -a : a;
      mb = (sgn && b[W-1]) ? -b : b;
      if (b == '0) e = mk('1, a, 1'b1, 1);
      else if (sgn && a == MIN_INT && b == '1) e = mk(MIN_INT, '0, 1'b0, EXP_LAT);
      else begin
         if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
         end else begin
            e.q = a / b;
            e.r = a % b;
         end
         e.dz  = 1'b0;
         e.lat = (EO_ON && ma < mb) ? 1 : EXP_LAT;
      end
      return e;
   endfunction

   task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int cycles, output int busy_cycles,
                            output bit timed_out);
      cycles = c0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && cycles < 200) begin
         if (bus.busy === 1'b1) busy_cycles++;
         @(negedge clk);
         cycles++;
      end
      timed_out = (bus.done !== 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
      end
      checks++;
      if (bus.quotient !== '0 || bus.remainder !== '0) begin
         errors++; $display("FAIL reset_results: got q=%h r=%h want 0", bus.quotient, bus.remainder);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divu();
      exp_t e; int cyc, bcyc; bit to;
      logic [W-1:0] a, b;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a = 32'd100; b = 32'd7; e = mk(32'd14, 32'd2, 1'b0, EXP_LAT);
         end else begin
            a = $urandom(); b = $urandom() >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            e = model(1'b0, a, b);
         end
         sb.push_back(e);
         issue(1'b0, a, b);
         wait_done(1, cyc, bcyc, to);
         e = sb.pop_front();
         checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL divu[%0d] latency: got %0d (timeout=%0d) want %0d", i, cyc, to, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL divu[%0d] quotient: got %h want %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL divu[%0d] remainder: got %h want %h", i, bus.remainder, e.r); end
         checks++; if (bus.div_by_zero !== e.dz) begin errors++; $display("FAIL divu[%0d] div_by_zero: got %b want %b", i, bus.div_by_zero, e.dz); end
         if (i == 0) begin
            checks++; if (bcyc != 32) begin errors++; $display("FAIL divu busy_cycles: got %0d want 32", bcyc); end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
               errors++; $display("FAIL divu hold: got done=%b q=%h r=%h want 0/0000000e/00000002", bus.done, bus.quotient, bus.remainder);
            end
         end
      end
   endtask

   task automatic test_signed();
      exp_t e; int cyc, bcyc; bit to;
      logic [W-1:0] a, b;
      logic [W-1:0] ta[2] = '{32'hFFFF_FFF9, 32'd7};
      logic [W-1:0] tbv[2] = '{32'd2, 32'hFFFF_FFFE};
      logic [W-1:0] tq[2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD};
      logic [W-1:0] tr[2] = '{32'hFFFF_FFFF, 32'd1};
      for (int i = 0; i < 6; i++) begin
         if (i < 2) begin
            a = ta[i]; b = tbv[i]; e = mk(tq[i], tr[i], 1'b0, EXP_LAT);
         end else begin
            a = $urandom(); b = $urandom() >> $urandom_range(8, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == '0 || b == '1) b = 32'd3;
            e = model(1'b1, a, b);
         end
         sb.push_back(e);
         issue(1'b1, a, b);
         wait_done(1, cyc, bcyc, to);
         e = sb.pop_front();
         checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL div[%0d] latency: got %0d (timeout=%0d) want %0d", i, cyc, to, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL div[%0d] quotient: got %h want %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL div[%0d] remainder: got %h want %h", i, bus.remainder, e.r); end
         checks++; if (bus.div_by_zero !== e.dz) begin errors++; $display("FAIL div[%0d] div_by_zero: got %b want %b", i, bus.div_by_zero, e.dz); end
      end
   endtask

   task automatic test_div_zero();
      exp_t e; int cyc, bcyc; bit to;
      bit sg[2] = '{1'b0, 1'b1};
      logic [W-1:0] ta[2] = '{32'h0000_1234, 32'hFFFF_FFFB};
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk('1, ta[i], 1'b1, 1));
         issue(sg[i], ta[i], '0);
         wait_done(1, cyc, bcyc, to);
         e = sb.pop_front();
         checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL dz[%0d] latency: got %0d (timeout=%0d) want %0d", i, cyc, to, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL dz[%0d] quotient: got %h want %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL dz[%0d] remainder: got %h want %h", i, bus.remainder, e.r); end
         checks++; if (bus.div_by_zero !== e.dz) begin errors++; $display("FAIL dz[%0d] div_by_zero: got %b want %b", i, bus.div_by_zero, e.dz); end
      end
   endtask

   task automatic test_overflow();
      exp_t e; int cyc, bcyc; bit to;
      bit sg[2] = '{1'b1, 1'b0};
      logic [W-1:0] ta[2] = '{MIN_INT, 32'hFFFF_FFFF};
      logic [W-1:0] tbv[2] = '{32'hFFFF_FFFF, 32'd1};
      logic [W-1:0] tq[2] = '{MIN_INT, 32'hFFFF_FFFF};
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(tq[i], '0, 1'b0, EXP_LAT));
         issue(sg[i], ta[i], tbv[i]);
         if (i == 0) begin
            // previous op was a divide by zero: flag clears at accept, results hold
            checks++;
            if (bus.div_by_zero !== 1'b0 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'hFFFF_FFFB) begin
               errors++; $display("FAIL ovf accept_state: got dz=%b q=%h r=%h want 0/ffffffff/fffffffb", bus.div_by_zero, bus.quotient, bus.remainder);
            end
         end
         wait_done(1, cyc, bcyc, to);
         e = sb.pop_front();
         checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL ovf[%0d] latency: got %0d (timeout=%0d) want %0d", i, cyc, to, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL ovf[%0d] quotient: got %h want %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL ovf[%0d] remainder: got %h want %h", i, bus.remainder, e.r); end
         checks++; if (bus.div_by_zero !== e.dz) begin errors++; $display("FAIL ovf[%0d] div_by_zero: got %b want %b", i, bus.div_by_zero, e.dz); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; int cyc, c0, bcyc; bit to;
      sb.push_back(mk(32'd333, 32'd1, 1'b0, EXP_LAT));
      issue(1'b0, 32'd1000, 32'd3);
      c0 = 1;
      for (int i = 0; i < 4; i++) begin
         bus.start = 1'b1; bus.is_signed = i[0];
         bus.dividend = 32'hDEAD_0000 + 32'(i);
         bus.divisor = (i < 2) ? '0 : 32'd1;
         @(negedge clk); c0++;
         bus.start = 1'b0;
         @(negedge clk); c0++;
      end
      wait_done(c0, cyc, bcyc, to);
      e = sb.pop_front();
      checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL ignore latency: got %0d (timeout=%0d) want %0d", cyc, to, e.lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL ignore quotient: got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL ignore remainder: got %h want %h", bus.remainder, e.r); end
      checks++; if (bus.div_by_zero !== e.dz) begin errors++; $display("FAIL ignore div_by_zero: got %b want %b", bus.div_by_zero, e.dz); end
      // start presented during the DONE cycle: -50 / -5
      sb.push_back(mk(32'd10, '0, 1'b0, EXP_LAT));
      bus.start = 1'b1; bus.is_signed = 1'b1;
      bus.dividend = 32'hFFFF_FFCE; bus.divisor = 32'hFFFF_FFFB;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errors++; $display("FAIL b2b no_gap: got busy=%b done=%b want 1/0", bus.busy, bus.done);
      end
      wait_done(1, cyc, bcyc, to);
      e = sb.pop_front();
      checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL b2b latency: got %0d (timeout=%0d) want %0d", cyc, to, e.lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL b2b quotient: got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL b2b remainder: got %h want %h", bus.remainder, e.r); end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      issue(1'b0, 32'd12345, 32'd7);
      repeat (9) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_run busy_before: got %b want 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         errors++; $display("FAIL rst_run flags: got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
      end
      checks++;
      if (bus.quotient !== '0 || bus.remainder !== '0) begin
         errors++; $display("FAIL rst_run results: got q=%h r=%h want 0", bus.quotient, bus.remainder);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_run no_done: got done pulse want none"); end
   endtask

   task automatic test_early_out();
      exp_t e; int cyc, bcyc; bit to;
      int eo_lat;
      bit sg[3] = '{1'b0, 1'b1, 1'b0};
      logic [W-1:0] ta[3] = '{32'd3, 32'hFFFF_FFFD, 32'd5};
      logic [W-1:0] tbv[3] = '{32'd5, 32'd5, 32'd5};
      logic [W-1:0] tq[3] = '{32'd0, 32'd0, 32'd1};
      logic [W-1:0] tr[3] = '{32'd3, 32'hFFFF_FFFD, 32'd0};
      eo_lat = EO_ON ? 1 : EXP_LAT;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(tq[i], tr[i], 1'b0, (i < 2) ? eo_lat : EXP_LAT));
         issue(sg[i], ta[i], tbv[i]);
         wait_done(1, cyc, bcyc, to);
         e = sb.pop_front();
         checks++; if (to || cyc != e.lat) begin errors++; $display("FAIL eo[%0d] latency: got %0d (timeout=%0d) want %0d", i, cyc, to, e.lat); end
         checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL eo[%0d] quotient: got %h want %h", i, bus.quotient, e.q); end
         checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL eo[%0d] remainder: got %h want %h", i, bus.remainder, e.r); end
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_div_zero();
      test_overflow();
      test_back_to_back();
      test_reset_mid_run();
      test_early_out();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
